// File: rtl/dispatch_queue_pkg.sv
// Shared constants for the dispatch stage: operand/tag widths, zero values, opcode encodings.
// Queue depth and CDB channel count defaults live here so the queue and its interface agree.
package dispatch_queue_pkg;

    localparam int ROB_ID_TYPE_W = 4;
    localparam int DATA_TYPE_W   = 32;
    localparam int OPENUM_W      = 6;

    localparam int DQ_DEPTH      = 8;
    localparam int DQ_NUM_CDB    = 2;

    localparam logic [ROB_ID_TYPE_W-1:0] ZERO_ROB  = '0;
    localparam logic [DATA_TYPE_W-1:0]   ZERO_WORD = '0;

    localparam logic [OPENUM_W-1:0] OPENUM_NOP  = 6'd0;
    localparam logic [OPENUM_W-1:0] OPENUM_ADD  = 6'd1;
    localparam logic [OPENUM_W-1:0] OPENUM_ADDI = 6'd2;
    localparam logic [OPENUM_W-1:0] OPENUM_BEQ  = 6'd3;
    localparam logic [OPENUM_W-1:0] OPENUM_LW   = 6'd4;
    localparam logic [OPENUM_W-1:0] OPENUM_SW   = 6'd5;

endpackage

// File: rtl/dispatch_queue_if.sv
// Packet, CDB, target-full and issue signals of the dispatch queue.
// master = upstream rename/CDB/target side, slave = the queue itself.
interface dispatch_queue_if import dispatch_queue_pkg::*; #(
    parameter int DEPTH    = DQ_DEPTH,
    parameter int NUM_CDB  = DQ_NUM_CDB,
    parameter int ROB_ID_W = ROB_ID_TYPE_W,
    parameter int DATA_W   = DATA_TYPE_W,
    parameter int OP_W     = OPENUM_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                         in_valid;
    logic                         in_ready;
    logic                         in_is_ls;
    logic [OP_W-1:0]              in_op;
    logic [ROB_ID_W-1:0]          in_q1;
    logic [ROB_ID_W-1:0]          in_q2;
    logic [DATA_W-1:0]            in_v1;
    logic [DATA_W-1:0]            in_v2;
    logic [DATA_W-1:0]            in_pc;
    logic [DATA_W-1:0]            in_imm;
    logic [ROB_ID_W-1:0]          in_rob_id;

    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id;
    logic [NUM_CDB*DATA_W-1:0]    cdb_result;

    logic                         rs_full;
    logic                         lsb_full;
    logic                         ena_to_rs;
    logic                         ena_to_lsb;
    logic [OP_W-1:0]              out_op;
    logic [ROB_ID_W-1:0]          out_q1;
    logic [ROB_ID_W-1:0]          out_q2;
    logic [DATA_W-1:0]            out_v1;
    logic [DATA_W-1:0]            out_v2;
    logic [DATA_W-1:0]            out_pc;
    logic [DATA_W-1:0]            out_imm;
    logic [ROB_ID_W-1:0]          out_rob_id;
    logic [CNT_W-1:0]             count;

    modport master (
        output in_valid, in_is_ls, in_op, in_q1, in_q2, in_v1, in_v2, in_pc, in_imm, in_rob_id,
        output cdb_valid, cdb_rob_id, cdb_result, rs_full, lsb_full,
        input  in_ready, ena_to_rs, ena_to_lsb, out_op, out_q1, out_q2, out_v1, out_v2,
        input  out_pc, out_imm, out_rob_id, count
    );

    modport slave (
        input  in_valid, in_is_ls, in_op, in_q1, in_q2, in_v1, in_v2, in_pc, in_imm, in_rob_id,
        input  cdb_valid, cdb_rob_id, cdb_result, rs_full, lsb_full,
        output in_ready, ena_to_rs, ena_to_lsb, out_op, out_q1, out_q2, out_v1, out_v2,
        output out_pc, out_imm, out_rob_id, count
    );

endinterface

// File: rtl/dispatch_queue_cdb_operand_resolve.sv
// Resolves one (tag, value) operand against all CDB channels; lowest matching channel wins.
// Purely combinational, no backpressure.
module cdb_operand_resolve import dispatch_queue_pkg::*; #(
    parameter int NUM_CDB  = DQ_NUM_CDB,
    parameter int ROB_ID_W = ROB_ID_TYPE_W,
    parameter int DATA_W   = DATA_TYPE_W
) (
    input  logic [ROB_ID_W-1:0]         q,
    input  logic [DATA_W-1:0]           v,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    output logic [ROB_ID_W-1:0]         q_res,
    output logic [DATA_W-1:0]           v_res
);

    // Scan high to low so the lowest-index match is the last assignment and takes effect.
    always_comb begin
        q_res = q;
        v_res = v;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (q != '0 && cdb_valid[i] && cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == q) begin
                q_res = '0;
                v_res = cdb_result[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between rename and RS/LSB, snooping the CDB for waiting operands.
// Issue one edge after accept at the earliest; a full head target stalls issue, in_ready drops when full.
module dispatch_queue import dispatch_queue_pkg::*; #(
    parameter int DEPTH    = DQ_DEPTH,
    parameter int NUM_CDB  = DQ_NUM_CDB,
    parameter int ROB_ID_W = ROB_ID_TYPE_W,
    parameter int DATA_W   = DATA_TYPE_W,
    parameter int OP_W     = OPENUM_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    dispatch_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic                is_ls;
        logic [OP_W-1:0]     op;
        logic [ROB_ID_W-1:0] q1;
        logic [DATA_W-1:0]   v1;
        logic [ROB_ID_W-1:0] q2;
        logic [DATA_W-1:0]   v2;
        logic [DATA_W-1:0]   pc;
        logic [DATA_W-1:0]   imm;
        logic [ROB_ID_W-1:0] rob_id;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]     op;
        logic [ROB_ID_W-1:0] q1;
        logic [DATA_W-1:0]   v1;
        logic [ROB_ID_W-1:0] q2;
        logic [DATA_W-1:0]   v2;
        logic [DATA_W-1:0]   pc;
        logic [DATA_W-1:0]   imm;
        logic [ROB_ID_W-1:0] rob_id;
    } issue_t;

    entry_t             mem [DEPTH];
    logic [DEPTH-1:0]   occ;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   cnt;
    issue_t             pay;
    logic               ena_rs;
    logic               ena_lsb;

    entry_t             head_e;
    logic [ROB_ID_W-1:0] in_q1_r, in_q2_r, hd_q1_r, hd_q2_r;
    logic [DATA_W-1:0]   in_v1_r, in_v2_r, hd_v1_r, hd_v2_r;
    logic [ROB_ID_W-1:0] sn_q1 [DEPTH];
    logic [ROB_ID_W-1:0] sn_q2 [DEPTH];
    logic [DATA_W-1:0]   sn_v1 [DEPTH];
    logic [DATA_W-1:0]   sn_v2 [DEPTH];
    logic               head_full;
    logic               do_enq;
    logic               do_iss;

    assign head_e = mem[head];

    cdb_operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_in_op1 (
        .q(bus.in_q1), .v(bus.in_v1), .cdb_valid(bus.cdb_valid), .cdb_rob_id(bus.cdb_rob_id),
        .cdb_result(bus.cdb_result), .q_res(in_q1_r), .v_res(in_v1_r)
    );
    cdb_operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_in_op2 (
        .q(bus.in_q2), .v(bus.in_v2), .cdb_valid(bus.cdb_valid), .cdb_rob_id(bus.cdb_rob_id),
        .cdb_result(bus.cdb_result), .q_res(in_q2_r), .v_res(in_v2_r)
    );
    cdb_operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_hd_op1 (
        .q(head_e.q1), .v(head_e.v1), .cdb_valid(bus.cdb_valid), .cdb_rob_id(bus.cdb_rob_id),
        .cdb_result(bus.cdb_result), .q_res(hd_q1_r), .v_res(hd_v1_r)
    );
    cdb_operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_hd_op2 (
        .q(head_e.q2), .v(head_e.v2), .cdb_valid(bus.cdb_valid), .cdb_rob_id(bus.cdb_rob_id),
        .cdb_result(bus.cdb_result), .q_res(hd_q2_r), .v_res(hd_v2_r)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
        cdb_operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_op1 (
            .q(mem[g].q1), .v(mem[g].v1), .cdb_valid(bus.cdb_valid), .cdb_rob_id(bus.cdb_rob_id),
            .cdb_result(bus.cdb_result), .q_res(sn_q1[g]), .v_res(sn_v1[g])
        );
        cdb_operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_op2 (
            .q(mem[g].q2), .v(mem[g].v2), .cdb_valid(bus.cdb_valid), .cdb_rob_id(bus.cdb_rob_id),
            .cdb_result(bus.cdb_result), .q_res(sn_q2[g]), .v_res(sn_v2[g])
        );
    end

    // in_ready looks only at registered occupancy, so a same-edge issue cannot re-open a full queue.
    assign bus.in_ready = (cnt < FULL_CNT);
    assign head_full    = head_e.is_ls ? bus.lsb_full : bus.rs_full;
    assign do_enq       = bus.in_valid && bus.in_ready;
    assign do_iss       = (cnt != '0) && !head_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            occ     <= '0;
            ena_rs  <= 1'b0;
            ena_lsb <= 1'b0;
            pay     <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            occ     <= '0;
            ena_rs  <= 1'b0;
            ena_lsb <= 1'b0;
        end else if (!rdy) begin
            ena_rs  <= 1'b0;
            ena_lsb <= 1'b0;
        end else begin
            ena_rs  <= do_iss && !head_e.is_ls;
            ena_lsb <= do_iss &&  head_e.is_ls;

            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i]) begin
                    mem[i].q1 <= sn_q1[i];
                    mem[i].v1 <= sn_v1[i];
                    mem[i].q2 <= sn_q2[i];
                    mem[i].v2 <= sn_v2[i];
                end
            end

            if (do_iss) begin
                pay <= '{op: head_e.op, q1: hd_q1_r, v1: hd_v1_r, q2: hd_q2_r, v2: hd_v2_r,
                         pc: head_e.pc, imm: head_e.imm, rob_id: head_e.rob_id};
                occ[head] <= 1'b0;
                head      <= head + 1'b1;
            end

            // tail is never an occupied slot while do_enq holds, so this write cannot clobber a snoop.
            if (do_enq) begin
                mem[tail] <= '{is_ls: bus.in_is_ls, op: bus.in_op, q1: in_q1_r, v1: in_v1_r,
                               q2: in_q2_r, v2: in_v2_r, pc: bus.in_pc, imm: bus.in_imm,
                               rob_id: bus.in_rob_id};
                occ[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end

            case ({do_enq, do_iss})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.ena_to_rs  = ena_rs;
    assign bus.ena_to_lsb = ena_lsb;
    assign bus.out_op     = pay.op;
    assign bus.out_q1     = pay.q1;
    assign bus.out_v1     = pay.v1;
    assign bus.out_q2     = pay.q2;
    assign bus.out_v2     = pay.v2;
    assign bus.out_pc     = pay.pc;
    assign bus.out_imm    = pay.imm;
    assign bus.out_rob_id = pay.rob_id;
    assign bus.count      = cnt;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed scenarios plus random traffic against a queue-based reference model of the dispatch queue.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int NCDB  = 2;
    localparam int RW    = 4;
    localparam int DW    = 32;
    localparam int OW    = 6;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    always #5 clk = ~clk;

    dispatch_queue_if #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .ROB_ID_W(RW), .DATA_W(DW), .OP_W(OW)) bus ();

    dispatch_queue #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .ROB_ID_W(RW), .DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
    );

    typedef struct {
        bit            is_ls;
        logic [OW-1:0] op;
        logic [RW-1:0] q1;
        logic [DW-1:0] v1;
        logic [RW-1:0] q2;
        logic [DW-1:0] v2;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic [RW-1:0] rob;
    } pkt_t;

    pkt_t mq[$];
    pkt_t exp_pay;
    bit   exp_rs, exp_lsb;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [RW-1:0] watch_rob;
    bit            cap_hit;
    logic [RW-1:0] cap_q1, cap_q2;
    logic [DW-1:0] cap_v1, cap_v2;
    int            pulses;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A waiting tag takes the value of the first valid channel carrying it; tag 0 is already ready.
    function automatic logic [RW+DW-1:0] res(input logic [RW-1:0] q, input logic [DW-1:0] v);
        if (q == ZERO_ROB) return {q, v};
        for (int i = 0; i < NCDB; i++)
            if (bus.cdb_valid[i] && bus.cdb_rob_id[i*RW +: RW] == q)
                return {ZERO_ROB, bus.cdb_result[i*DW +: DW]};
        return {q, v};
    endfunction

    task automatic model_step();
        bit   accept;
        pkt_t h, e;
        if (rst) begin
            mq.delete();
            exp_rs = 0; exp_lsb = 0;
            exp_pay = '{default: 0};
            return;
        end
        if (flush) begin
            mq.delete();
            exp_rs = 0; exp_lsb = 0;
            return;
        end
        exp_rs = 0; exp_lsb = 0;
        if (!rdy) return;
        accept = bus.in_valid && (mq.size() < DEPTH);
        if (mq.size() > 0 && !(mq[0].is_ls ? bus.lsb_full : bus.rs_full)) begin
            h = mq.pop_front();
            {h.q1, h.v1} = res(h.q1, h.v1);
            {h.q2, h.v2} = res(h.q2, h.v2);
            exp_pay = h;
            if (h.is_ls) exp_lsb = 1; else exp_rs = 1;
        end
        foreach (mq[i]) begin
            e = mq[i];
            {e.q1, e.v1} = res(e.q1, e.v1);
            {e.q2, e.v2} = res(e.q2, e.v2);
            mq[i] = e;
        end
        if (accept) begin
            e.is_ls = bus.in_is_ls; e.op = bus.in_op; e.pc = bus.in_pc;
            e.imm = bus.in_imm; e.rob = bus.in_rob_id;
            {e.q1, e.v1} = res(bus.in_q1, bus.in_v1);
            {e.q2, e.v2} = res(bus.in_q2, bus.in_v2);
            mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        check("ena_to_rs", bus.ena_to_rs, exp_rs);
        check("ena_to_lsb", bus.ena_to_lsb, exp_lsb);
        check("count", bus.count, mq.size());
        check("in_ready", bus.in_ready, mq.size() < DEPTH);
        check("payload",
              {bus.out_op, bus.out_q1, bus.out_v1, bus.out_q2, bus.out_v2, bus.out_pc, bus.out_imm, bus.out_rob_id},
              {exp_pay.op, exp_pay.q1, exp_pay.v1, exp_pay.q2, exp_pay.v2, exp_pay.pc, exp_pay.imm, exp_pay.rob});
        if (bus.ena_to_rs || bus.ena_to_lsb) begin
            pulses++;
            if (bus.out_rob_id == watch_rob) begin
                cap_hit = 1;
                cap_q1 = bus.out_q1; cap_v1 = bus.out_v1;
                cap_q2 = bus.out_q2; cap_v2 = bus.out_v2;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0;
        bus.in_valid = 0; bus.rs_full = 0; bus.lsb_full = 0;
        bus.cdb_valid = '0; bus.cdb_rob_id = '0; bus.cdb_result = '0;
    endtask

    task automatic pkt(input bit ls, input logic [RW-1:0] rob, input logic [RW-1:0] q1,
                       input logic [DW-1:0] v1, input logic [RW-1:0] q2, input logic [DW-1:0] v2);
        bus.in_valid = 1; bus.in_is_ls = ls; bus.in_rob_id = rob;
        bus.in_q1 = q1; bus.in_v1 = v1; bus.in_q2 = q2; bus.in_v2 = v2;
        bus.in_op = ls ? OPENUM_LW : OPENUM_ADD;
        bus.in_pc = $urandom; bus.in_imm = $urandom;
    endtask

    task automatic set_cdb(input int ch, input logic [RW-1:0] tag, input logic [DW-1:0] val);
        bus.cdb_valid[ch] = 1'b1;
        bus.cdb_rob_id[ch*RW +: RW] = tag;
        bus.cdb_result[ch*DW +: DW] = val;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            step();
        end
    endtask

    initial begin
        idle();
        pkt(0, 0, 0, 0, 0, 0);
        bus.in_valid = 0;
        watch_rob = 0; cap_hit = 0; pulses = 0;
        rst = 1;
        step();
        step();

        // In-order issue to alternating targets, no stall.
        idle(); pkt(0, 1, 0, 32'h11, 0, 32'h12); step();
        idle(); pkt(1, 2, 0, 32'h21, 0, 32'h22); step();
        idle(); pkt(0, 3, 0, 32'h31, 0, 32'h32); step();
        drain(3);
        check("t1_count_end", bus.count, 0);

        // Fill behind a full RS, then try one extra enqueue, then drain.
        for (int i = 0; i < DEPTH + 1; i++) begin
            idle(); pkt(0, RW'(i + 1), 0, $urandom, 0, $urandom); bus.rs_full = 1; step();
        end
        check("t2_full_count", bus.count, DEPTH);
        check("t2_full_ready", bus.in_ready, 0);
        pulses = 0;
        drain(12);
        check("t2_pulses", pulses, DEPTH);

        // Waiting operand behind a stalled head picks up CDB channel 1.
        idle(); pkt(0, 1, 0, 32'h1, 0, 32'h2); bus.rs_full = 1; step();
        idle(); pkt(0, 2, 5, 32'h0, 0, 32'h3); bus.rs_full = 1; step();
        idle(); bus.rs_full = 1; set_cdb(1, 5, 32'hDEAD_BEEF); step();
        watch_rob = 2; cap_hit = 0;
        drain(4);
        check("t3_hit", cap_hit, 1);
        check("t3_q1", cap_q1, 0);
        check("t3_v1", cap_v1, 32'hDEAD_BEEF);

        // Operand resolved on the enqueue edge itself.
        idle(); pkt(0, 3, 0, 32'h5, 7, 32'h0); bus.rs_full = 1; set_cdb(0, 7, 32'h10); step();
        idle(); bus.rs_full = 1; step();
        watch_rob = 3; cap_hit = 0;
        drain(3);
        check("t4_hit", cap_hit, 1);
        check("t4_q2", cap_q2, 0);
        check("t4_v2", cap_v2, 32'h10);

        // Two channels carry the same tag: channel 0 wins.
        idle(); pkt(0, 6, 4, 32'h0, 0, 32'h9); bus.rs_full = 1; step();
        idle(); bus.rs_full = 1; set_cdb(0, 4, 32'hA); set_cdb(1, 4, 32'hB); step();
        watch_rob = 6; cap_hit = 0;
        drain(3);
        check("t5_hit", cap_hit, 1);
        check("t5_v1", cap_v1, 32'hA);

        // Flush with five buffered and a packet on offer.
        for (int i = 0; i < 5; i++) begin
            idle(); pkt(i % 2 == 1, RW'(i + 8), 0, $urandom, 0, $urandom);
            bus.rs_full = 1; bus.lsb_full = 1; step();
        end
        idle(); pkt(0, 15, 0, 32'h77, 0, 32'h78); flush = 1; step();
        check("t6_flush_count", bus.count, 0);
        pulses = 0;
        drain(4);
        check("t6_no_pulse", pulses, 0);

        // rdy low for three cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            idle(); pkt($urandom_range(0, 1), RW'(i + 1), 0, $urandom, 0, $urandom);
            if (i >= 3 && i <= 5) rdy = 0;
            step();
        end
        drain(10);
        check("t7_count_end", bus.count, 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            idle();
            rdy = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 79) == 0);
            bus.rs_full = ($urandom_range(0, 2) == 0);
            bus.lsb_full = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                pkt($urandom_range(0, 1), RW'($urandom_range(1, 15)),
                    ($urandom_range(0, 1) == 1) ? RW'($urandom_range(1, 15)) : ZERO_ROB, $urandom,
                    ($urandom_range(0, 1) == 1) ? RW'($urandom_range(1, 15)) : ZERO_ROB, $urandom);
            for (int ch = 0; ch < NCDB; ch++)
                if ($urandom_range(0, 1) == 1) set_cdb(ch, RW'($urandom_range(0, 15)), $urandom);
            step();
        end
        drain(DEPTH + 2);
        check("rand_count_end", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor to the single-slot dispatch stage.
- Buffers renamed instruction packets (operands already resolved against regfile and ROB) in a DEPTH-entry circular queue.
- Snoops NUM_CDB broadcast channels every cycle so that buffered operands waiting on a ROB tag capture their values.
- Issues the head entry in order to the RS or the LSB when the target has space; the RS and LSB can therefore stall dispatch without dropping instructions, and a rollback flush empties the queue.

Parameters:
- DEPTH, 8: queue entries; power of two, ≥2.
- NUM_CDB, 2: CDB channels snooped; 1..4.
- ROB_ID_W, 4: ROB tag width; tag 0 means "operand ready".
- DATA_W, 32: data/address width.
- OP_W, 6: openum width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction rollback; empties the queue
- in_valid  in  1  packet offered
- in_ready  out  1  queue can accept; combinational, equals count<DEPTH
- in_is_ls  in  1  packet targets the LSB, else the RS
- in_op  in  OP_W  openum
- in_q1, in_q2  in  ROB_ID_W  source tags
- in_v1, in_v2  in  DATA_W  source values
- in_pc  in  DATA_W  instruction pc
- in_imm  in  DATA_W  immediate
- in_rob_id  in  ROB_ID_W  destination ROB tag
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_rob_id  in  NUM_CDB*ROB_ID_W  packed tags; channel i occupies bits [i*ROB_ID_W +: ROB_ID_W]
- cdb_result  in  NUM_CDB*DATA_W  packed results
- rs_full, lsb_full  in  1  target cannot accept this cycle
- ena_to_rs, ena_to_lsb  out  1  one-cycle issue pulse
- out_op, out_q1, out_q2, out_v1, out_v2, out_pc, out_imm, out_rob_id  out  as inputs  issue payload, shared by RS and LSB
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
Reset:
- Head and tail pointers, count, ena_to_rs and ena_to_lsb all 0.
- Payload outputs 0; entry valid bits cleared.

Priority:
- rst > flush > ~rdy > normal operation.

Enqueue:
- Occurs on a clock edge with in_valid && in_ready && rdy && !flush.
- The entry is written at tail; tail wraps modulo DEPTH.
- The incoming q1/q2 are first resolved against the same-cycle CDB: on a match, the tag is set to 0 and v takes cdb_result.
- A nonzero tag never matches tag 0.

Snoop:
- Every rdy cycle, each occupied entry whose qN≠0 and equals cdb_rob_id[i] with cdb_valid[i] set clears qN and loads vN.
- If several channels carry the same tag, the lowest channel index wins.

Issue:
- Issue is evaluated at each edge.
- Condition: count>0, rdy, !flush, and the head target is not full (lsb_full if is_ls, else rs_full).
- On issue, the matching ena is driven high for exactly the next cycle and the payload is registered from the head entry with the same-cycle CDB resolution applied. Head then advances and wraps.
- Otherwise both ena outputs are 0 and the payload holds its last value.
- At most one issue per cycle.
- Strictly in order: a stalled head blocks younger entries even if their target is free.

Latency and occupancy:
- Packet accepted at edge N issues at edge N+1 at the earliest (ena visible during cycle N+1).
- Simultaneous enqueue and issue keep count unchanged.
- When full, in_ready is 0; a same-edge issue does not re-open in_ready within that cycle.

Flush:
- Next edge clears pointers, count and both ena outputs.
- Any concurrent enqueue or issue is discarded.

rdy low:
- Pointers, entries and count are frozen and snoop is suppressed.
- Both ena outputs are forced to 0 so that no issue is duplicated.

Other rules:
- is_ls is stored per entry; out_pc is forwarded to both targets.
- The queue performs no arithmetic beyond pointer increment modulo DEPTH and count ±1 saturating within 0..DEPTH.

Decomposition:
- Shared package/constants file: ZERO_ROB, ZERO_WORD, OPENUM_* encodings, ROB_ID_TYPE/DATA_TYPE widths (existing constant.v).
- New constants: DQ_DEPTH default, NUM_CDB default.
- One sub-module: cdb_operand_resolve. It is combinational and takes q, v and the packed CDB buses, returning the resolved (q, v).
- cdb_operand_resolve is instantiated for the two input operands, the two head operands, and per entry for the snoop.

Test Plan:
- Reset then 3 enqueues (RS, LSB, RS; rob 1,2,3) with no stall: ena_to_rs at cycles 1 and 3, ena_to_lsb at cycle 2, out_rob_id 1,2,3; count ends 0.
- rs_full held high, 8 enqueues: count=8, in_ready=0, no ena. Release rs_full: 8 consecutive ena_to_rs pulses in order, pointers wrap correctly.
- Entry with q1=5 buffered behind a stalled head; CDB channel 1 broadcasts rob 5 with 0xDEAD_BEEF. On issue: out_q1=0, out_v1=0xDEADBEEF.
- Enqueue with in_q2=7 on the same edge that CDB0 broadcasts rob 7 with 0x10: the stored entry has q2=0, v2=0x10.
- CDB0 and CDB1 both broadcast tag 4, with values 0xA and 0xB: the waiting operand receives 0xA.
- Queue holding 5 entries, flush asserted together with in_valid: next cycle count=0, no ena pulse, and the offered packet is not stored. rdy low for 3 cycles mid-stream: no ena, count unchanged, and issue resumes in order.
